mul_share_ctrl: RTL and testbench

Controller that shares one sequential 8x8 shift-add multiplier core (multiplier8x8) between two requesters. It accepts requests over valid/ready handshakes, arbitrates round-robin, and drives the core's operands and restart pulse. It times the core's fixed latency, captures the 16-bit product and returns it to the winning requester over a valid/ready response handshake. It sits between client logic and the single multiplier instance. The multiplier's reset input is driven by mul_start.

---
 rtl/mul_share_ctrl_if.sv | 45 ++++
 rtl/mul_share_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_ctrl_if.sv
// Purpose : Bundle of the request, response and multiplier-core signals that
//           mul_share_ctrl arbitrates. Clock and reset stay plain ports.
// Modports: slave  - the controller (consumes requests, drives the core)
//           master - the client/core side (drives requests and mul_product)
// Signals : req{0,1}_valid/_a/_b/_ready   request handshakes, 8-bit operands
//           resp{0,1}_valid/_product/_ready response handshakes, 16-bit product
//           mul_start/mul_a/mul_b/mul_product shared multiplier core
//           busy                          controller not in IDLE
interface mul_share_ctrl_if;
  logic        req0_valid;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic        req1_ready;
  logic        resp0_valid;
  logic [15:0] resp0_product;
  logic        resp0_ready;
  logic        resp1_valid;
  logic [15:0] resp1_product;
  logic        resp1_ready;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_product;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  resp0_ready, resp1_ready, mul_product,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_product, resp1_valid, resp1_product,
    output mul_start, mul_a, mul_b, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output resp0_ready, resp1_ready, mul_product,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_product, resp1_valid, resp1_product,
    input  mul_start, mul_a, mul_b, busy
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// Purpose : Shares one sequential 8x8 multiplier core between two requesters.
//           Round-robin arbitration in IDLE, one-cycle restart pulse to the
//           core, fixed-latency wait, then the product is returned to the
//           owner over a valid/ready response held until taken.
// Ports   : clk    - rising-edge clock
//           areset - synchronous active-high reset
//           bus    - mul_share_ctrl_if.slave (requests, responses, core)
// Params  : MUL_LATENCY - cycles after the mul_start cycle until the core
//                         product is final (1..255)
//           CNT_W       - latency counter width, must hold MUL_LATENCY
module mul_share_ctrl #(
  parameter int unsigned MUL_LATENCY = 9,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              areset,
  mul_share_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         mul_a_q, mul_a_d;
  logic [7:0]         mul_b_q, mul_b_d;
  logic               resp0_valid_q, resp0_valid_d;
  logic               resp1_valid_q, resp1_valid_d;
  logic [15:0]        resp0_product_q, resp0_product_d;
  logic [15:0]        resp1_product_q, resp1_product_d;

  logic               any_valid_s;
  logic               grant_s;
  logic               cnt_last_s;
  logic               resp_take_s;
  logic               req0_ready_s;
  logic               req1_ready_s;
  logic               mul_start_s;
  logic               busy_s;

  // Round-robin grant: a lone requester wins; on a tie the one not served last.
  always_comb begin
    any_valid_s = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_s = ~last_grant_q;
    end else begin
      grant_s = bus.req1_valid;
    end
    cnt_last_s  = (cnt_q == CNT_W'(1));
    resp_take_s = owner_q ? (resp1_valid_q & bus.resp1_ready)
                          : (resp0_valid_q & bus.resp0_ready);
  end

  // State register and all datapath flops; reset beats every other update.
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= 1'b1;
      owner_q         <= 1'b0;
      cnt_q           <= '0;
      mul_a_q         <= 8'd0;
      mul_b_q         <= 8'd0;
      resp0_valid_q   <= 1'b0;
      resp1_valid_q   <= 1'b0;
      resp0_product_q <= 16'd0;
      resp1_product_q <= 16'd0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      mul_a_q         <= mul_a_d;
      mul_b_q         <= mul_b_d;
      resp0_valid_q   <= resp0_valid_d;
      resp1_valid_q   <= resp1_valid_d;
      resp0_product_q <= resp0_product_d;
      resp1_product_q <= resp1_product_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (cnt_last_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_take_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: operand latch, latency counter, response capture.
  always_comb begin
    last_grant_d    = last_grant_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    mul_a_d         = mul_a_q;
    mul_b_d         = mul_b_q;
    resp0_valid_d   = resp0_valid_q;
    resp1_valid_d   = resp1_valid_q;
    resp0_product_d = resp0_product_q;
    resp1_product_d = resp1_product_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_s) begin
          mul_a_d      = grant_s ? bus.req1_a : bus.req0_a;
          mul_b_d      = grant_s ? bus.req1_b : bus.req0_b;
          owner_d      = grant_s;
          last_grant_d = grant_s;
        end else begin
          owner_d      = owner_q;
        end
      end
      ST_START: begin
        cnt_d = CNT_W'(MUL_LATENCY);
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Counter reading 1 marks the last WAIT cycle; the core is final now.
        if (cnt_last_s) begin
          if (owner_q) begin
            resp1_product_d = bus.mul_product;
            resp1_valid_d   = 1'b1;
          end else begin
            resp0_product_d = bus.mul_product;
            resp0_valid_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_take_s) begin
          if (owner_q) begin
            resp1_valid_d = 1'b0;
          end else begin
            resp0_valid_d = 1'b0;
          end
        end else begin
          owner_d = owner_q;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Outputs decoded from state; ready is combinational so a request is taken
  // in the same cycle it is granted.
  always_comb begin
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    if ((state_q == ST_IDLE) && !areset && any_valid_s) begin
      req0_ready_s = ~grant_s;
      req1_ready_s = grant_s;
    end else begin
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
    end
    mul_start_s = (state_q == ST_START);
    busy_s      = (state_q != ST_IDLE);
  end

  assign bus.req0_ready    = req0_ready_s;
  assign bus.req1_ready    = req1_ready_s;
  assign bus.mul_start     = mul_start_s;
  assign bus.busy          = busy_s;
  assign bus.mul_a         = mul_a_q;
  assign bus.mul_b         = mul_b_q;
  assign bus.resp0_valid   = resp0_valid_q;
  assign bus.resp1_valid   = resp1_valid_q;
  assign bus.resp0_product = resp0_product_q;
  assign bus.resp1_product = resp1_product_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural shift-add core model.
module tb_mul_share_ctrl;

  logic clk = 1'b0;
  logic areset;
  int   total = 0;
  int   bad   = 0;

  mul_share_ctrl_if bus ();

  mul_share_ctrl #(.MUL_LATENCY(9), .CNT_W(8)) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Shift-add core: restarted by mul_start, one partial product per cycle,
  // final 9 cycles after the mul_start cycle.
  logic [15:0] core_acc = 16'd0;
  logic [3:0]  core_cnt = 4'd8;
  always @(posedge clk) begin
    if (bus.mul_start) begin
      core_acc <= 16'd0;
      core_cnt <= 4'd0;
    end else if (core_cnt < 4'd8) begin
      if (bus.mul_b[core_cnt[2:0]])
        core_acc <= core_acc + ({8'd0, bus.mul_a} << core_cnt);
      core_cnt <= core_cnt + 4'd1;
    end
  end
  assign bus.mul_product = core_acc;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for requester n's ready, then take the accepting edge.
  task automatic accept(input bit n);
    int k = 0;
    #1;
    while (((n ? bus.req1_ready : bus.req0_ready) !== 1'b1) && k < 20) begin
      tick();
      #1;
      k++;
    end
    chk(n ? "req1_ready" : "req0_ready", n ? bus.req1_ready : bus.req0_ready, 1);
    chk(n ? "req0_ready_other" : "req1_ready_other", n ? bus.req0_ready : bus.req1_ready, 0);
    tick();
  endtask

  // Wait (bounded) for resp n valid and check the response; does not tick past it.
  task automatic wait_resp(input bit n, input logic [15:0] exp);
    int k = 0;
    while (((n ? bus.resp1_valid : bus.resp0_valid) !== 1'b1) && k < 30) begin
      chk("busy_during_op", bus.busy, 1);
      tick();
      k++;
    end
    chk(n ? "resp1_valid" : "resp0_valid", n ? bus.resp1_valid : bus.resp0_valid, 1);
    chk(n ? "resp1_product" : "resp0_product", n ? bus.resp1_product : bus.resp0_product, exp);
    chk("nonowner_valid", n ? bus.resp0_valid : bus.resp1_valid, 0);
    chk("busy_resp", bus.busy, 1);
  endtask

  task automatic op(input bit n, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    if (n) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
    accept(n);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("op_mul_start", bus.mul_start, 1);
    chk("op_busy_start", bus.busy, 1);
    wait_resp(n, exp);
    tick();
    chk("op_busy_idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    areset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = 8'd0; bus.req0_b = 8'd0;
    bus.req1_valid = 1'b0; bus.req1_a = 8'd0; bus.req1_b = 8'd0;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_mul_start", bus.mul_start, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_resp0_valid", bus.resp0_valid, 0);
    chk("rst_resp1_valid", bus.resp1_valid, 0);
    chk("rst_resp0_product", bus.resp0_product, 0);
    chk("rst_resp1_product", bus.resp1_product, 0);
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_req0_ready", bus.req0_ready, 0);
    bus.req0_valid = 1'b0;
    areset = 1'b0;

    // Single request 255*100 with exact latency.
    bus.req0_valid = 1'b1; bus.req0_a = 8'd255; bus.req0_b = 8'd100;
    accept(1'b0);
    bus.req0_valid = 1'b0;
    chk("t1_mul_start", bus.mul_start, 1);
    chk("t1_mul_a", bus.mul_a, 255);
    chk("t1_mul_b", bus.mul_b, 100);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("t1_wait_start", bus.mul_start, 0);
      chk("t1_wait_valid", bus.resp0_valid, 0);
      chk("t1_wait_busy", bus.busy, 1);
    end
    tick();
    chk("t1_resp0_valid", bus.resp0_valid, 1);
    chk("t1_resp0_product", bus.resp0_product, 16'h639C);
    chk("t1_resp1_valid", bus.resp1_valid, 0);
    tick();
    chk("t1_valid_drop", bus.resp0_valid, 0);
    chk("t1_product_kept", bus.resp0_product, 16'h639C);
    chk("t1_busy_idle", bus.busy, 0);

    // Corners on requester 1.
    op(1'b1, 8'd255, 8'd255, 16'hFE01);
    op(1'b1, 8'd1, 8'd1, 16'd1);
    op(1'b1, 8'd0, 8'd200, 16'd0);

    // Simultaneous requests from a fresh reset: requester 0 first.
    areset = 1'b1;
    tick();
    areset = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd4;
    bus.req1_valid = 1'b1; bus.req1_a = 8'd5; bus.req1_b = 8'd6;
    accept(1'b0);
    bus.req0_valid = 1'b0;
    wait_resp(1'b0, 16'd12);
    tick();
    accept(1'b1);
    bus.req0_valid = 1'b1;
    wait_resp(1'b1, 16'd30);
    tick();
    for (int i = 0; i < 4; i++) begin
      accept(i[0]);
      wait_resp(i[0], i[0] ? 16'd30 : 16'd12);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Backpressure on response 1 with a pending request 0.
    bus.req1_valid = 1'b1; bus.req1_a = 8'd200; bus.req1_b = 8'd3;
    accept(1'b1);
    bus.req1_valid = 1'b0;
    bus.resp1_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 8'd10; bus.req0_b = 8'd10;
    wait_resp(1'b1, 16'd600);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", bus.resp1_valid, 1);
      chk("bp_product_held", bus.resp1_product, 600);
      chk("bp_req0_ready", bus.req0_ready, 0);
      chk("bp_req1_ready", bus.req1_ready, 0);
      tick();
    end
    bus.resp1_ready = 1'b1;
    #1;
    chk("bp_valid_last", bus.resp1_valid, 1);
    chk("bp_req0_ready_last", bus.req0_ready, 0);
    tick();
    chk("bp_valid_clear", bus.resp1_valid, 0);
    chk("bp_req0_ready_idle", bus.req0_ready, 1);
    chk("bp_mul_a_unsampled", bus.mul_a, 200);
    tick();
    bus.req0_valid = 1'b0;
    chk("bp_mul_a_new", bus.mul_a, 10);
    wait_resp(1'b0, 16'd100);
    tick();

    // Reset in the middle of WAIT.
    bus.req0_valid = 1'b1; bus.req0_a = 8'd7; bus.req0_b = 8'd9;
    accept(1'b0);
    bus.req0_valid = 1'b0;
    repeat (3) tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("mr_busy", bus.busy, 0);
    chk("mr_mul_start", bus.mul_start, 0);
    chk("mr_mul_a", bus.mul_a, 0);
    chk("mr_mul_b", bus.mul_b, 0);
    chk("mr_resp0_product", bus.resp0_product, 0);
    for (int i = 0; i < 15; i++) begin
      chk("mr_no_resp", bus.resp0_valid, 0);
      chk("mr_no_start", bus.mul_start, 0);
      tick();
    end
    op(1'b0, 8'd7, 8'd9, 16'd63);

    // Operand stability while the request inputs wander.
    bus.req0_valid = 1'b1; bus.req0_a = 8'd13; bus.req0_b = 8'd17;
    accept(1'b0);
    bus.req0_valid = 1'b0;
    for (int k = 0; k < 30 && bus.resp0_valid !== 1'b1; k++) begin
      bus.req0_a = 8'($urandom);
      bus.req0_b = 8'($urandom);
      #1;
      chk("os_mul_a", bus.mul_a, 13);
      chk("os_mul_b", bus.mul_b, 17);
      tick();
    end
    wait_resp(1'b0, 16'd221);
    tick();
    chk("os_mul_a_idle", bus.mul_a, 13);
    chk("os_mul_b_idle", bus.mul_b, 17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
